serial_tx_sequencer: RTL and testbench
======================================

SERIAL_TX_SEQUENCER -- requirements
Module: serial_tx_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning word length in bits (minimum 2).
REQ-002 SHALL have parameter DIV_WIDTH, default 16, meaning width of the bit-period divider.
REQ-003 SHALL have port CLK, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RSTN, input, 1, meaning reset; reset is asynchronous and active-low.
REQ-005 SHALL have port DIN, input, WIDTH, meaning parallel word to transmit, sampled on accept.
REQ-006 SHALL have port DIN_VALID, input, 1, meaning DIN holds a word for transmission.
REQ-007 SHALL have port DIN_READY, output, 1, meaning the sequencer accepts a word this cycle.
REQ-008 SHALL have port DIV, input, DIV_WIDTH, meaning bit period minus one in CLK cycles, sampled on accept.
REQ-009 SHALL have port ABORT, input, 1, meaning synchronous cancel of the frame in progress.
REQ-010 SHALL have port SOUT, output, 1, meaning serial data, MSB first.
REQ-011 SHALL have port FRAME, output, 1, meaning a frame is on the line.
REQ-012 SHALL have port BIT_STB, output, 1, meaning one-cycle pulse on the last cycle of each bit period.
REQ-013 SHALL have port DONE, output, 1, meaning one-cycle pulse after a frame completes normally.

Function
REQ-014 SHALL implement states IDLE and SHIFT only.
REQ-015 DIN_READY SHALL be 1 exactly when state is IDLE and ABORT is 0.
REQ-016 Accept SHALL be DIN_VALID and DIN_READY both 1 at a rising edge; on accept the shifter loads DIN (LOAD=1, CE=1), DIV is latched, state goes to SHIFT, bit counter and divider clear.
REQ-017 In SHIFT, the divider SHALL count 0..latched DIV; BIT_STB is 1 in the cycle where divider equals latched DIV.
REQ-018 On each BIT_STB that is not the WIDTH-th, the shifter SHALL shift once (CE=1, LOAD=0) and the bit counter increments.
REQ-019 On the WIDTH-th BIT_STB, state SHALL return to IDLE, and DONE is 1 in the following cycle only.
REQ-020 FRAME SHALL be 1 exactly while state is SHIFT; SOUT is the shifter MSB while FRAME is 1 and 0 otherwise.
REQ-021 A frame SHALL last exactly WIDTH*(DIV+1) cycles, each bit held DIV+1 cycles; DIV=0 gives one cycle per bit.
REQ-022 Changes on DIN or DIV during SHIFT SHALL have no effect on the frame in progress.
REQ-023 ABORT=1 in SHIFT SHALL return state to IDLE at the next edge, with no DONE and no BIT_STB in that cycle; ABORT in IDLE blocks accept.
REQ-024 Back-to-back: a word presented during the DONE cycle SHALL be accepted then, giving one idle line cycle between frames.
REQ-025 In IDLE, the shifter CE SHALL be 0 except on accept.

Reset
REQ-026 While RSTN=0: state IDLE, counters 0, shifter cleared, DIN_READY=1 once RSTN=1, SOUT=0, FRAME=0, BIT_STB=0, DONE=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame immediately with no DONE pulse.

Structure
REQ-028 State encoding and the minimum-WIDTH constant SHALL live in the shared serial-IO package.
REQ-029 The data path SHALL be one instance of the codebase's ParallelToSerial shift register (same WIDTH, INITIAL_VALUE zero), driven through its LOAD/CE/RSTN/CLK; no other sub-module.

Verification
REQ-030 WIDTH=8, DIV=0, DIN=8'hA5 accepted -> SOUT 1,0,1,0,0,1,0,1 on 8 consecutive cycles, FRAME high 8 cycles, DONE one cycle after.
REQ-031 DIV=3, DIN=8'h81 -> each bit held 4 cycles, FRAME high 32 cycles, 8 BIT_STB pulses spaced 4 cycles.
REQ-032 DIN_VALID held high with words 8'hF0 then 8'h0F, DIV=0 -> second accepted on DONE cycle, exactly one FRAME-low cycle between frames.
REQ-033 DIV=2, ABORT pulsed at cycle 7 of frame -> FRAME low next cycle, no DONE, DIN_READY high.
REQ-034 RSTN low at cycle 5 of a DIV=1 frame -> FRAME, SOUT, BIT_STB drop asynchronously, no DONE after release.
REQ-035 DIN and DIV toggled every cycle during a frame -> transmitted bits and timing match values sampled at accept.

Source files
------------

// File: rtl/serial_tx_sequencer_pkg.sv
// Shared serial-IO definitions: sequencer state encoding and word-size floor.
package serial_tx_sequencer_pkg;

    // Smallest word the sequencer can frame.
    localparam int MIN_WIDTH = 2;

    // Sequencer states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/serial_tx_sequencer_p2s.sv
// ParallelToSerial: loadable left-shift register presenting its MSB serially.
module ParallelToSerial #(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] INITIAL_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             LOAD,
    input  logic             CE,
    input  logic [WIDTH-1:0] DIN,
    output logic             SOUT
);

    logic [WIDTH-1:0] sreg;

    // Load a fresh word or shift left by one (zero fill) when enabled.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sreg <= INITIAL_VALUE;
        end else if (CE) begin
            if (LOAD) sreg <= DIN;
            else      sreg <= {sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign SOUT = sreg[WIDTH-1];

endmodule

// File: rtl/serial_tx_sequencer.sv
// Serial transmit sequencer: frames a parallel word MSB first, each bit held
// DIV+1 clocks, with abort, completion pulse and back-to-back acceptance.
module serial_tx_sequencer
    import serial_tx_sequencer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [WIDTH-1:0]     DIN,
    input  logic                 DIN_VALID,
    output logic                 DIN_READY,
    input  logic [DIV_WIDTH-1:0] DIV,
    input  logic                 ABORT,
    output logic                 SOUT,
    output logic                 FRAME,
    output logic                 BIT_STB,
    output logic                 DONE
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    generate
        if (WIDTH < MIN_WIDTH) begin : g_width_chk
            $error("serial_tx_sequencer: WIDTH below minimum");
        end
    endgenerate

    state_t               state, state_nxt;
    logic [DIV_WIDTH-1:0] div_lat;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [CW-1:0]        bit_cnt;
    logic                 done_r;
    logic                 accept;
    logic                 last_bit;
    logic                 sh_load;
    logic                 sh_ce;
    logic                 sh_msb;

    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state: accept starts a frame; abort or the final strobe ends it.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (DIN_VALID && !ABORT)    state_nxt = ST_SHIFT;
            ST_SHIFT: if (ABORT)                  state_nxt = ST_IDLE;
                      else if (BIT_STB && last_bit) state_nxt = ST_IDLE;
            default:                              state_nxt = ST_IDLE;
        endcase
    end

    // Outputs and shifter controls decoded from state; abort masks the strobe.
    always_comb begin
        DIN_READY = 1'b0;
        FRAME     = 1'b0;
        BIT_STB   = 1'b0;
        accept    = 1'b0;
        sh_load   = 1'b0;
        sh_ce     = 1'b0;
        case (state)
            ST_IDLE: begin
                DIN_READY = !ABORT;
                accept    = DIN_VALID && !ABORT;
                sh_load   = accept;
                sh_ce     = accept;
            end
            ST_SHIFT: begin
                FRAME   = 1'b1;
                BIT_STB = !ABORT && (div_cnt == div_lat);
                sh_ce   = BIT_STB && !last_bit;
            end
            default: ;
        endcase
    end

    // Divider, bit counter, latched period and the delayed completion pulse.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            div_lat <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= BIT_STB && last_bit;
            if (accept) begin
                div_lat <= DIV;
                div_cnt <= '0;
                bit_cnt <= '0;
            end else if (state == ST_SHIFT) begin
                if (BIT_STB) begin
                    div_cnt <= '0;
                    bit_cnt <= bit_cnt + CW'(1);
                end else begin
                    div_cnt <= div_cnt + DIV_WIDTH'(1);
                end
            end
        end
    end

    assign DONE = done_r;
    assign SOUT = FRAME && sh_msb;

    ParallelToSerial #(
        .WIDTH         (WIDTH),
        .INITIAL_VALUE ('0)
    ) u_p2s (
        .CLK  (CLK),
        .RSTN (RSTN),
        .LOAD (sh_load),
        .CE   (sh_ce),
        .DIN  (DIN),
        .SOUT (sh_msb)
    );

endmodule

// File: tb/tb_serial_tx_sequencer.sv
// Directed bench for serial_tx_sequencer (WIDTH=8, DIV_WIDTH=16).
module tb_serial_tx_sequencer;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic [7:0]  DIN;
    logic        DIN_VALID;
    logic        DIN_READY;
    logic [15:0] DIV;
    logic        ABORT;
    logic        SOUT;
    logic        FRAME;
    logic        BIT_STB;
    logic        DONE;

    int checks = 0;
    int errors = 0;

    serial_tx_sequencer #(.WIDTH(8), .DIV_WIDTH(16)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .DIN_READY (DIN_READY),
        .DIV       (DIV),
        .ABORT     (ABORT),
        .SOUT      (SOUT),
        .FRAME     (FRAME),
        .BIT_STB   (BIT_STB),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    // Present one word for a single accept edge, then drop DIN_VALID.
    task automatic send(input logic [7:0] w, input logic [15:0] d);
        @(negedge CLK);
        DIN = w; DIV = d; DIN_VALID = 1'b1;
        checks++;
        if (DIN_READY !== 1'b1) begin
            errors++; $display("FAIL send_ready: got %b want 1", DIN_READY);
        end
        @(posedge CLK); #1;
        DIN_VALID = 1'b0;
    endtask

    // Check one sampled cycle against expected outputs.
    task automatic expect_cyc(input string nm, input int c, input logic f,
                              input logic s, input logic b, input logic dn);
        checks++;
        if ({FRAME, SOUT, BIT_STB, DONE} !== {f, s, b, dn}) begin
            errors++;
            $display("FAIL %s cyc %0d: got FRAME/SOUT/STB/DONE=%b%b%b%b want %b%b%b%b",
                     nm, c, FRAME, SOUT, BIT_STB, DONE, f, s, b, dn);
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0; DIN = '0; DIN_VALID = 1'b0; DIV = '0; ABORT = 1'b0;
        #12;
        checks++;
        if ({FRAME, SOUT, BIT_STB, DONE} !== 4'b0000) begin
            errors++; $display("FAIL reset_outs: got %b want 0000", {FRAME, SOUT, BIT_STB, DONE});
        end
        @(negedge CLK); RSTN = 1'b1;
        @(negedge CLK);
        checks++;
        if (DIN_READY !== 1'b1 || FRAME !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got ready=%b frame=%b want 1 0", DIN_READY, FRAME);
        end
    endtask

    // A5, one cycle per bit.
    task automatic test_basic();
        logic [7:0] w = 8'hA5;
        send(w, 16'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK); expect_cyc("basic", c, 1'b1, w[7-c], 1'b1, 1'b0);
        end
        @(negedge CLK); expect_cyc("basic_done", 8, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge CLK); expect_cyc("basic_post", 9, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // 81 with each bit held four cycles.
    task automatic test_div3();
        logic [7:0] w = 8'h81;
        int stb = 0;
        send(w, 16'd3);
        for (int c = 0; c < 32; c++) begin
            @(negedge CLK);
            if (BIT_STB === 1'b1) stb++;
            expect_cyc("div3", c, 1'b1, w[7-c/4], (c % 4) == 3, 1'b0);
        end
        checks++;
        if (stb != 8) begin
            errors++; $display("FAIL div3_stb_count: got %0d want 8", stb);
        end
        @(negedge CLK); expect_cyc("div3_done", 32, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // DIN_VALID held; second word taken on the DONE cycle.
    task automatic test_back_to_back();
        logic [7:0] w0 = 8'hF0;
        logic [7:0] w1 = 8'h0F;
        int lows = 0;
        @(negedge CLK);
        DIN = w0; DIV = 16'd0; DIN_VALID = 1'b1;
        @(posedge CLK); #1;
        DIN = w1;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK); expect_cyc("b2b_f0", c, 1'b1, w0[7-c], 1'b1, 1'b0);
        end
        @(negedge CLK);
        if (FRAME === 1'b0) lows++;
        expect_cyc("b2b_gap", 8, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (DIN_READY !== 1'b1) begin
            errors++; $display("FAIL b2b_ready: got %b want 1", DIN_READY);
        end
        @(posedge CLK); #1;
        DIN_VALID = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (FRAME === 1'b0) lows++;
            expect_cyc("b2b_0f", 9 + c, 1'b1, w1[7-c], 1'b1, 1'b0);
        end
        @(negedge CLK); expect_cyc("b2b_done", 17, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (lows != 1) begin
            errors++; $display("FAIL b2b_gap_count: got %0d want 1", lows);
        end
    endtask

    // Abort at frame cycle 7 (mid-bit) and at cycle 2 (a strobe cycle).
    task automatic test_abort();
        logic [7:0] w = 8'hFF;
        int cyc [2] = '{7, 2};
        for (int k = 0; k < 2; k++) begin
            send(w, 16'd2);
            for (int c = 0; c < cyc[k]; c++) begin
                @(negedge CLK); expect_cyc("abort_pre", c, 1'b1, 1'b1, (c % 3) == 2, 1'b0);
            end
            @(posedge CLK); #1; ABORT = 1'b1;
            @(negedge CLK);
            expect_cyc("abort_cyc", cyc[k], 1'b1, 1'b1, 1'b0, 1'b0);
            @(posedge CLK); #1; ABORT = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge CLK); expect_cyc("abort_after", c, 1'b0, 1'b0, 1'b0, 1'b0);
                checks++;
                if (DIN_READY !== 1'b1) begin
                    errors++; $display("FAIL abort_ready: got %b want 1", DIN_READY);
                end
            end
        end
        // Abort in idle blocks acceptance.
        @(negedge CLK); ABORT = 1'b1; DIN_VALID = 1'b1;
        #1;
        checks++;
        if (DIN_READY !== 1'b0) begin
            errors++; $display("FAIL abort_idle_ready: got %b want 0", DIN_READY);
        end
        @(posedge CLK); #1; ABORT = 1'b0; DIN_VALID = 1'b0;
        @(negedge CLK); expect_cyc("abort_idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset asserted at cycle 5 of a DIV=1 frame.
    task automatic test_reset_mid();
        send(8'hFF, 16'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK); expect_cyc("rst_pre", c, 1'b1, 1'b1, (c % 2) == 1, 1'b0);
        end
        @(posedge CLK); #2; RSTN = 1'b0;
        #1;
        expect_cyc("rst_async", 5, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK); RSTN = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK); expect_cyc("rst_after", c, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (DIN_READY !== 1'b1) begin
            errors++; $display("FAIL rst_ready: got %b want 1", DIN_READY);
        end
    endtask

    // DIN/DIV scrambled throughout the frame.
    task automatic test_toggle();
        logic [7:0] w = 8'hC6;
        send(w, 16'd1);
        for (int c = 0; c < 16; c++) begin
            DIN = ~DIN ^ 8'($urandom);
            DIV = 16'($urandom_range(0, 7));
            @(negedge CLK); expect_cyc("toggle", c, 1'b1, w[7-c/2], (c % 2) == 1, 1'b0);
            @(posedge CLK); #1;
        end
        @(negedge CLK); expect_cyc("toggle_done", 16, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div3();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, simulation did not finish");
        $fatal(1);
    end

endmodule
